// File: rtl/mips_cpu_multdiv.sv
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// One shift-add or restoring-subtract step per clock; 33 cycles from START to result.
module mips_cpu_multdiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  RESET_N,
    input  logic                  START,
    input  logic [2:0]            OP,
    input  logic [DATA_WIDTH-1:0] RsDATA,
    input  logic [DATA_WIDTH-1:0] RtDATA,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t         state, state_next;
    logic [CW-1:0]  cnt;
    logic           is_div, neg_main, neg_rem;
    logic [W-1:0]   upper, low, divisor, rs_raw;

    logic           start_arith;
    logic           a_neg, b_neg;
    logic [W-1:0]   mag_a, mag_b;
    logic [W:0]     mult_sum, div_tmp, div_diff;
    logic [2*W-1:0] prod, fin_result;
    logic [W-1:0]   quo, rem;

    always_ff @(posedge clk) begin
        if (!RESET_N)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_arith) state_next = RUN;
            RUN:     if (cnt == CW'(W - 1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state != IDLE);
    end

    // Signed ops iterate on magnitudes; signs are re-applied once at FINISH.
    always_comb begin
        start_arith = START && !OP[2];
        a_neg       = !OP[0] && RsDATA[W-1];
        b_neg       = !OP[0] && RtDATA[W-1];
        mag_a       = a_neg ? -RsDATA : RsDATA;
        mag_b       = b_neg ? -RtDATA : RtDATA;
    end

    // {upper,low} is the product accumulator for mult and {remainder,quotient} for div.
    always_comb begin
        mult_sum = {1'b0, upper} + (low[0] ? {1'b0, divisor} : '0);
        div_tmp  = {upper, low[W-1]};
        div_diff = div_tmp - {1'b0, divisor};
    end

    // Most-negative / -1 falls out naturally: magnitude quotient 2^(W-1) negates to itself.
    always_comb begin
        prod = {upper, low};
        quo  = neg_main ? -low : low;
        rem  = neg_rem ? -upper : upper;
        if (!is_div)
            fin_result = neg_main ? -prod : prod;
        else if (divisor == '0)
            fin_result = {rs_raw, {W{1'b1}}};
        else
            fin_result = {rem, quo};
    end

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            upper    <= '0;
            low      <= '0;
            divisor  <= '0;
            rs_raw   <= '0;
            HI       <= '0;
            LO       <= '0;
            DONE     <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START && OP == 3'b100) HI <= RsDATA;
                    if (START && OP == 3'b101) LO <= RsDATA;
                    if (start_arith) begin
                        is_div   <= OP[1];
                        neg_main <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        upper    <= '0;
                        low      <= mag_a;
                        divisor  <= mag_b;
                        rs_raw   <= RsDATA;
                        cnt      <= '0;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (!is_div) begin
                        upper <= mult_sum[W:1];
                        low   <= {mult_sum[0], low[W-1:1]};
                    end else if (!div_diff[W]) begin
                        upper <= div_diff[W-1:0];
                        low   <= {low[W-2:0], 1'b1};
                    end else begin
                        upper <= div_tmp[W-1:0];
                        low   <= {low[W-2:0], 1'b0};
                    end
                end
                FINISH: begin
                    HI   <= fin_result[2*W-1:W];
                    LO   <= fin_result[W-1:0];
                    DONE <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mips_cpu_multdiv.md
Name: mips_cpu_multdiv

Overview:
- Iterative multiply/divide unit holding the architectural HI/LO registers.
- Sits directly downstream of the register file. It consumes the registered Rs/Rt read data for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- HI/LO are exposed continuously to the writeback mux for MFHI/MFLO.
- BUSY lets the control unit stall the next HI/LO access until the operation completes.

Parameters:
- DATA_WIDTH, 32, operand/HI/LO width; iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  rising-edge clock
- RESET_N  input  1  synchronous, active-low reset
- START  input  1  request; sampled only when BUSY=0
- OP  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op
- RsDATA  input  DATA_WIDTH  operand A / dividend / MTHI-MTLO source
- RtDATA  input  DATA_WIDTH  operand B / divisor
- BUSY  output  1  high while a mult/div is iterating
- DONE  output  1  one-cycle pulse after HI/LO take a mult/div result
- HI  output  DATA_WIDTH  HI register
- LO  output  DATA_WIDTH  LO register

Behaviour:
- Reset (RESET_N=0 at a clk edge) has priority over everything:
  - state=IDLE; HI=LO=0; BUSY=0; DONE=0; iteration counter=0.
  - Applies mid-operation: the in-flight result is discarded.
- States: IDLE, RUN, FINISH.
- IDLE:
  - START=1 with OP=MTHI/MTLO: write RsDATA into HI/LO at that edge. Stay IDLE; no BUSY, no DONE.
  - START=1 with OP in 000..011, at edge k:
    - Latch operands. Signed ops take magnitudes and record result signs.
    - Clear the counter and go to RUN; BUSY=1 from edge k.
  - START=1 with OP 110/111: ignored.
- RUN: one shift-add (mult) or one restoring-subtract (div) step per edge. The counter increments each edge. After 32 steps (edge k+32) go to FINISH.
- FINISH (edge k+33):
  - Apply sign correction and write HI/LO. BUSY=0 and DONE=1 from edge k+33. Return to IDLE.
  - DONE drops at the next edge unless that edge also finishes another operation.
- Total latency: START edge to HI/LO update is 33 cycles. A new START is accepted in the cycle DONE is high.
- START while BUSY=1 is ignored for all OPs, including MTHI/MTLO. HI/LO are unchanged until FINISH.
- HI/LO hold their previous values throughout RUN.
- MULT/MULTU: the 64-bit product goes to {HI,LO}. MULT is two's-complement signed. MULTU is unsigned.
- DIV/DIVU: LO=quotient, HI=remainder.
  - DIV truncates toward zero; the remainder takes the sign of the dividend.
- Special cases, checked at FINISH:
  - Divisor=0 (DIV or DIVU): LO=FFFFFFFF, HI=RsDATA as latched.
  - DIV 80000000 / FFFFFFFF: LO=80000000, HI=00000000.
- Operands are captured at START. Later changes on RsDATA/RtDATA have no effect.

Test Plan:
- Reset, then MULT Rs=FFFFFFFD (-3), Rt=00000007 -> BUSY high for 33 cycles; DONE pulse; HI=FFFFFFFF, LO=FFFFFFEB.
- MULTU Rs=Rt=FFFFFFFF -> HI=FFFFFFFE, LO=00000001. Same operands with MULT -> HI=00000000, LO=00000001.
- DIV Rs=FFFFFFF9 (-7), Rt=00000002 -> LO=FFFFFFFD, HI=FFFFFFFF.
- DIVU Rs=00000064, Rt=00000000 -> LO=FFFFFFFF, HI=00000064.
- DIV Rs=80000000, Rt=FFFFFFFF -> LO=80000000, HI=00000000.
- Control and reset cases:
  - MTHI 12345678 while idle -> HI=12345678 next cycle, DONE stays 0.
  - MTLO issued while BUSY -> ignored.
  - RESET_N=0 at RUN cycle 10 -> HI=LO=0, BUSY=0, no DONE pulse.
